i2c_eeprom_ctrl: RTL and testbench
==================================

Name: i2c_eeprom_ctrl

Overview:
Byte-level sequencer between the I2C slave bit engine and the ROM/EEPROM memory inside i2c_slave_top. It owns the 16-bit EEPROM address pointer. It decodes the two-byte offset written by the master and prefetches memory bytes for sequential reads. It issues optional memory writes and tells the engine whether to ACK each received byte. Supports random read (write offset, repeated START, read N) and current-address read.

Parameters:
ADDR_W, 16, memory address width; pointer wraps at 2^ADDR_W; unused high bits of the offset are dropped.
MEM_LAT, 1, cycles from out_mem_rd to in_mem_rdata valid (1..4).
WRITE_EN, 0, 1 = data bytes after the offset are written to memory; 0 = they are NACKed and discarded.

Ports:
in_ext_osc  input  1  system clock (66 MHz)
in_reset_n  input  1  asynchronous active-low reset
in_start  input  1  pulse: START or repeated START detected
in_stop  input  1  pulse: STOP detected
in_addr_match  input  1  pulse: device address matched, ACK phase
in_rw  input  1  R/W bit, valid with in_addr_match (1 = read)
in_rx_valid  input  1  pulse: master-written byte received
in_rx_data  input  8  received byte, valid with in_rx_valid
out_ack_en  output  1  engine ACKs the next received byte when 1
in_tx_req  input  1  pulse: engine loads the next byte to shift out
out_tx_data  output  8  byte to transmit
out_tx_valid  output  1  out_tx_data holds a prefetched byte
in_master_nack  input  1  pulse: master NACKed a transmitted byte
out_mem_addr  output  ADDR_W  memory address
out_mem_rd  output  1  one-cycle read strobe
in_mem_rdata  input  8  read data, MEM_LAT cycles after out_mem_rd
out_mem_wr  output  1  one-cycle write strobe (always 0 if WRITE_EN=0)
out_mem_wdata  output  8  write data
out_ptr  output  ADDR_W  current address pointer
out_underrun  output  1  one-cycle pulse: in_tx_req arrived with out_tx_valid=0

Behaviour:
- Reset (async assert, sync release) sets all outputs to 0 except out_ack_en=1 and out_tx_data=8'hFF. State goes to IDLE; the pointer and the staged offset high byte are cleared.
- States:
  - IDLE: waiting for START.
  - DEV: START seen, waiting for in_addr_match.
  - OFS_HI, OFS_LO: receiving the two offset bytes.
  - WR_DATA: receiving data bytes after the offset.
  - RD_FETCH: memory read in flight.
  - RD_HOLD: prefetched byte waiting for in_tx_req.
  - RD_DONE: master NACKed; waiting for STOP or START.
- in_start from any state goes to DEV, clears out_tx_valid and aborts any in-flight fetch (returning data is ignored). The pointer is kept.
- in_stop from any state goes to IDLE with the pointer kept. If in_start and in_stop arrive in the same cycle, START wins.
- DEV + in_addr_match:
  - in_rw=0: go to OFS_HI.
  - in_rw=1: assert out_mem_rd with out_mem_addr=ptr, go to RD_FETCH.
- OFS_HI + in_rx_valid: stage the high byte, go to OFS_LO.
- OFS_LO + in_rx_valid: ptr <= {hi, byte} truncated to ADDR_W, go to WR_DATA. The pointer only loads after both bytes arrive; STOP after one byte leaves ptr unchanged.
- WR_DATA + in_rx_valid:
  - WRITE_EN=1: pulse out_mem_wr at ptr with the received data, then ptr <= ptr+1.
  - WRITE_EN=0: byte dropped, ptr unchanged.
- out_ack_en: 1 in IDLE, DEV, OFS_HI, OFS_LO. In WR_DATA it equals WRITE_EN. It is 1 in the read states, where the engine ignores it.
- RD_FETCH: exactly MEM_LAT cycles after out_mem_rd, latch in_mem_rdata into out_tx_data, set out_tx_valid=1, go to RD_HOLD.
- in_tx_req with out_tx_valid=1: clear out_tx_valid, ptr <= ptr+1, issue out_mem_rd at the new ptr the same cycle, go to RD_FETCH. The engine samples out_tx_data in the in_tx_req cycle.
- in_tx_req with out_tx_valid=0:
  - Pulse out_underrun and present out_tx_data=8'hFF.
  - ptr is not incremented.
  - The pending fetch completes normally.
- in_master_nack goes to RD_DONE and discards any prefetched or in-flight byte. The pointer is not incremented for unconsumed prefetches, so after a read the pointer equals the last transmitted address +1.
- The pointer wraps from 2^ADDR_W-1 to 0, for both writes and reads.
- Pulses in states where they are not expected (in_rx_valid during a read, in_tx_req outside the read states) are ignored. in_tx_req outside the read states does not pulse out_underrun.

Test Plan:
- Random read: START, 0x50 write, offset 0x00 0x01, repeated START, 0x50 read, 4 tx_req, NACK, STOP -> tx bytes mem[0x0001..0x0004], ptr=0x0005, exactly 5 out_mem_rd.
- Wrap: offset 0xFFFF, read 2 -> mem[0xFFFF] then mem[0x0000]; ptr=0x0001.
- Current-address read after the previous scenario: START, read, 3 bytes -> mem[0x0001..0x0003] (that scenario leaves ptr=0x0001).
- WRITE_EN=0: offset 0xAACC then data 0x5A -> out_ack_en=1 for both offset bytes, 0 for the data byte; no out_mem_wr; ptr=0xAACC. Same stimulus with WRITE_EN=1 -> write of 0x5A at 0xAACC, ptr=0xAACD.
- Partial offset: offset high byte 0x12 only, then STOP -> ptr unchanged. MEM_LAT=3 with tx_req 1 cycle after addr_match -> out_underrun pulse, tx_data 0xFF, ptr unchanged.
- Reset: assert in_reset_n low during RD_FETCH -> outputs at reset values immediately (asynchronously), ptr=0, no out_mem_rd after release.

Source files
------------

// File: rtl/i2c_eeprom_ctrl.sv
// i2c_eeprom_ctrl: byte-level sequencer between the I2C slave bit engine and
// the EEPROM/ROM. Owns the address pointer, decodes the two-byte offset,
// prefetches read bytes and optionally writes received data bytes.
module i2c_eeprom_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MEM_LAT  = 1,
  parameter bit          WRITE_EN = 1'b0
) (
  input  logic              in_ext_osc,
  input  logic              in_reset_n,
  input  logic              in_start,
  input  logic              in_stop,
  input  logic              in_addr_match,
  input  logic              in_rw,
  input  logic              in_rx_valid,
  input  logic [7:0]        in_rx_data,
  output logic              out_ack_en,
  input  logic              in_tx_req,
  output logic [7:0]        out_tx_data,
  output logic              out_tx_valid,
  input  logic              in_master_nack,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_rd,
  input  logic [7:0]        in_mem_rdata,
  output logic              out_mem_wr,
  output logic [7:0]        out_mem_wdata,
  output logic [ADDR_W-1:0] out_ptr,
  output logic              out_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEV,
    ST_OFS_HI,
    ST_OFS_LO,
    ST_WR_DATA,
    ST_RD_FETCH,
    ST_RD_HOLD,
    ST_RD_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   ptr_inc;
  logic [7:0]          ofs_hi_q, ofs_hi_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                tx_valid_q, tx_valid_d;
  logic                ack_q, ack_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                urun_q, urun_d;
  logic [2:0]          lat_q, lat_d;
  logic [15:0]         ofs_full;

  assign ptr_inc  = ptr_q + ADDR_W'(1);
  assign ofs_full = {ofs_hi_q, in_rx_data};

  // Next-state and next-output computation; START beats STOP beats per-state handling.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    ofs_hi_d   = ofs_hi_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    urun_d     = 1'b0;

    if (in_start) begin
      // Aborts any fetch: RD_FETCH is left, so the returning byte is never latched.
      state_d    = ST_DEV;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'hFF;
    end else if (in_stop) begin
      // A held prefetch is dropped too; the pointer never counted it.
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'hFF;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_DEV: begin
          if (in_addr_match) begin
            if (in_rw) begin
              rd_d    = 1'b1;
              addr_d  = ptr_q;
              lat_d   = 3'(MEM_LAT);
              state_d = ST_RD_FETCH;
            end else begin
              state_d = ST_OFS_HI;
            end
          end
        end
        ST_OFS_HI: begin
          if (in_rx_valid) begin
            ofs_hi_d = in_rx_data;
            state_d  = ST_OFS_LO;
          end
        end
        ST_OFS_LO: begin
          if (in_rx_valid) begin
            ptr_d   = ADDR_W'(ofs_full);
            state_d = ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (in_rx_valid && WRITE_EN) begin
            wr_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = in_rx_data;
            ptr_d   = ptr_inc;
          end
        end
        ST_RD_FETCH: begin
          if (in_master_nack) begin
            state_d = ST_RD_DONE;
          end else begin
            if (lat_q == 3'd0) begin
              tx_data_d  = in_mem_rdata;
              tx_valid_d = 1'b1;
              state_d    = ST_RD_HOLD;
            end else begin
              lat_d = lat_q - 3'd1;
            end
            if (in_tx_req) begin
              urun_d = 1'b1;
            end
          end
        end
        ST_RD_HOLD: begin
          if (in_master_nack) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'hFF;
            state_d    = ST_RD_DONE;
          end else if (in_tx_req) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'hFF;
            ptr_d      = ptr_inc;
            addr_d     = ptr_inc;
            rd_d       = 1'b1;
            lat_d      = 3'(MEM_LAT);
            state_d    = ST_RD_FETCH;
          end
        end
        ST_RD_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    ack_d = (state_d == ST_WR_DATA) ? WRITE_EN : 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      ofs_hi_q   <= '0;
      tx_data_q  <= '1;
      tx_valid_q <= 1'b0;
      wdata_q    <= '0;
      lat_q      <= '0;
      ack_q      <= 1'b1;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      ofs_hi_q   <= ofs_hi_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      ack_q      <= ack_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      urun_q     <= urun_d;
    end
  end

  assign out_ack_en    = ack_q;
  assign out_tx_data   = tx_data_q;
  assign out_tx_valid  = tx_valid_q;
  assign out_mem_addr  = addr_q;
  assign out_mem_rd    = rd_q;
  assign out_mem_wr    = wr_q;
  assign out_mem_wdata = wdata_q;
  assign out_ptr       = ptr_q;
  assign out_underrun  = urun_q;

endmodule

// File: tb/tb_i2c_eeprom_ctrl.sv
// Bench for i2c_eeprom_ctrl: three instances (LAT1/WE0, LAT1/WE1, LAT3/WE0)
// share one stimulus stream; a transaction-level model tracks pointer, fetch
// readiness and expected strobes and is compared on every cycle.
module tb_i2c_eeprom_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0, stop_i = 1'b0, am_i = 1'b0, rw_i = 1'b0;
  logic rxv_i = 1'b0, txreq_i = 1'b0, nack_i = 1'b0;
  logic [7:0] rxd_i = 8'h00;

  logic        ack_o [3];
  logic        txv_o [3];
  logic        rd_o  [3];
  logic        wr_o  [3];
  logic        ur_o  [3];
  logic [7:0]  txd_o [3];
  logic [7:0]  wd_o  [3];
  logic [7:0]  rdata [3];
  logic [15:0] addr_o [3];
  logic [15:0] ptr_o  [3];
  logic [16:0] pipe [3][4];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int rd_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic bit we_of(input int k);
    return k == 1;
  endfunction

  // Memory contents: a simple address hash so every byte is distinguishable.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] + 8'(3 * int'(a[15:8])) + 8'h11;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    i2c_eeprom_ctrl #(
      .ADDR_W  (16),
      .MEM_LAT ((k == 2) ? 3 : 1),
      .WRITE_EN(k == 1)
    ) dut (
      .in_ext_osc    (clk),
      .in_reset_n    (rst_n),
      .in_start      (start_i),
      .in_stop       (stop_i),
      .in_addr_match (am_i),
      .in_rw         (rw_i),
      .in_rx_valid   (rxv_i),
      .in_rx_data    (rxd_i),
      .out_ack_en    (ack_o[k]),
      .in_tx_req     (txreq_i),
      .out_tx_data   (txd_o[k]),
      .out_tx_valid  (txv_o[k]),
      .in_master_nack(nack_i),
      .out_mem_addr  (addr_o[k]),
      .out_mem_rd    (rd_o[k]),
      .in_mem_rdata  (rdata[k]),
      .out_mem_wr    (wr_o[k]),
      .out_mem_wdata (wd_o[k]),
      .out_ptr       (ptr_o[k]),
      .out_underrun  (ur_o[k])
    );
  end

  // Memory read latency: data is valid only in the cycle exactly MEM_LAT after the strobe.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) pipe[k][i] <= '0;
      end else begin
        for (int i = 3; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
        pipe[k][0] <= {rd_o[k], addr_o[k]};
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rdata[k] = pipe[k][lat_of(k)-1][16] ? mem(pipe[k][lat_of(k)-1][15:0]) : 8'hEE;
    end
  end

  // Model state
  logic [15:0] e_ptr [3];
  logic [15:0] e_addr [3];
  logic [15:0] e_wa [3];
  logic [7:0]  e_wd [3];
  bit          e_pend [3];
  bit          e_ack [3];
  int          e_rdy [3];
  int          e_rdc [3];
  int          e_wrc [3];
  int          e_urc [3];
  int          rd_base [3];
  logic [7:0]  got0 [$];
  logic [7:0]  got2 [$];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cyc=%0d actual=%0h expected=%0h", nm, k, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (e_pend[k] && (cyc >= e_rdy[k])) begin
        chk("tx_valid", k, 32'(txv_o[k]), 32'd1);
        chk("tx_data", k, 32'(txd_o[k]), 32'(mem(e_addr[k])));
      end else begin
        chk("tx_valid", k, 32'(txv_o[k]), 32'd0);
        chk("tx_data_idle", k, 32'(txd_o[k]), 32'hFF);
      end
      chk("ptr", k, 32'(ptr_o[k]), 32'(e_ptr[k]));
      chk("ack_en", k, 32'(ack_o[k]), 32'(e_ack[k]));
      chk("underrun", k, 32'(ur_o[k]), 32'(cyc == e_urc[k]));
      chk("mem_rd", k, 32'(rd_o[k]), 32'(cyc == e_rdc[k]));
      chk("mem_wr", k, 32'(wr_o[k]), 32'(cyc == e_wrc[k]));
      if (rd_o[k]) rd_cnt[k]++;
      if (cyc == e_rdc[k]) chk("rd_addr", k, 32'(addr_o[k]), 32'(e_addr[k]));
      if (cyc == e_wrc[k]) begin
        chk("wr_addr", k, 32'(addr_o[k]), 32'(e_wa[k]));
        chk("wr_data", k, 32'(wd_o[k]), 32'(e_wd[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      e_ptr[k] = '0; e_addr[k] = '0; e_wa[k] = '0; e_wd[k] = '0;
      e_pend[k] = 1'b0; e_ack[k] = 1'b1;
      e_rdy[k] = 0; e_rdc[k] = -1; e_wrc[k] = -1; e_urc[k] = -1;
    end
  endtask

  task automatic do_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin e_pend[k] = 1'b0; e_ack[k] = 1'b1; end
  endtask

  task automatic do_stop();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    for (int k = 0; k < 3; k++) begin e_pend[k] = 1'b0; e_ack[k] = 1'b1; end
  endtask

  task automatic do_addr(input bit rw);
    am_i = 1'b1; rw_i = rw; tick(); am_i = 1'b0; rw_i = 1'b0;
    if (rw) begin
      for (int k = 0; k < 3; k++) begin
        e_addr[k] = e_ptr[k];
        e_rdc[k]  = cyc;
        e_rdy[k]  = cyc + lat_of(k) + 1;
        e_pend[k] = 1'b1;
      end
    end
  endtask

  task automatic do_rx(input logic [7:0] b);
    rxv_i = 1'b1; rxd_i = b; tick(); rxv_i = 1'b0;
  endtask

  task automatic do_offset(input logic [7:0] hi, input logic [7:0] lo);
    do_rx(hi);
    do_rx(lo);
    for (int k = 0; k < 3; k++) begin e_ptr[k] = {hi, lo}; e_ack[k] = we_of(k); end
  endtask

  task automatic do_data(input logic [7:0] b);
    do_rx(b);
    for (int k = 0; k < 3; k++) begin
      if (we_of(k)) begin
        e_wrc[k] = cyc; e_wa[k] = e_ptr[k]; e_wd[k] = b; e_ptr[k] = e_ptr[k] + 16'd1;
      end
    end
  endtask

  task automatic do_txreq();
    bit v [3];
    for (int k = 0; k < 3; k++) v[k] = e_pend[k] && (cyc >= e_rdy[k]);
    if (v[0]) got0.push_back(txd_o[0]);
    if (v[2]) got2.push_back(txd_o[2]);
    txreq_i = 1'b1; tick(); txreq_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (v[k]) begin
        e_ptr[k]  = e_ptr[k] + 16'd1;
        e_addr[k] = e_ptr[k];
        e_rdc[k]  = cyc;
        e_rdy[k]  = cyc + lat_of(k) + 1;
      end else begin
        e_urc[k] = cyc;
      end
    end
  endtask

  task automatic do_nack();
    nack_i = 1'b1; tick(); nack_i = 1'b0;
    for (int k = 0; k < 3; k++) e_pend[k] = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 3; k++) rd_base[k] = 0;
    #7;
    chk("rst_ptr", 0, 32'(ptr_o[0]), 32'h0);
    chk("rst_ack", 0, 32'(ack_o[0]), 32'h1);
    chk("rst_txd", 0, 32'(txd_o[0]), 32'hFF);
    chk("rst_txv", 0, 32'(txv_o[0]), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Random read from 0x0001, four bytes
    do_start(); do_addr(1'b0); do_offset(8'h00, 8'h01);
    do_start();
    for (int k = 0; k < 3; k++) rd_base[k] = rd_cnt[k];
    got0.delete(); got2.delete();
    do_addr(1'b1); idle(6);
    repeat (4) begin do_txreq(); idle(6); end
    do_nack(); do_stop(); idle(2);
    chk("s1_n", 0, 32'(got0.size()), 32'd4);
    chk("s1_b0", 0, 32'(got0[0]), 32'h12);
    chk("s1_b1", 0, 32'(got0[1]), 32'h13);
    chk("s1_b2", 0, 32'(got0[2]), 32'h14);
    chk("s1_b3", 0, 32'(got0[3]), 32'h15);
    chk("s1_b3", 2, 32'(got2[3]), 32'h15);
    chk("s1_ptr", 0, 32'(ptr_o[0]), 32'h0005);
    chk("s1_rd_count", 0, 32'(rd_cnt[0] - rd_base[0]), 32'd5);
    chk("s1_rd_count", 2, 32'(rd_cnt[2] - rd_base[2]), 32'd5);

    // Wrap from 0xFFFF
    do_start(); do_addr(1'b0); do_offset(8'hFF, 8'hFF);
    do_start(); got0.delete();
    do_addr(1'b1); idle(6);
    repeat (2) begin do_txreq(); idle(6); end
    do_nack(); do_stop(); idle(2);
    chk("s2_b0", 0, 32'(got0[0]), 32'h0D);
    chk("s2_b1", 0, 32'(got0[1]), 32'h11);
    chk("s2_ptr", 0, 32'(ptr_o[0]), 32'h0001);

    // Current-address read
    do_start(); got0.delete();
    do_addr(1'b1); idle(6);
    repeat (3) begin do_txreq(); idle(6); end
    do_nack(); do_stop(); idle(2);
    chk("s3_n", 0, 32'(got0.size()), 32'd3);
    chk("s3_b0", 0, 32'(got0[0]), 32'h12);
    chk("s3_b2", 0, 32'(got0[2]), 32'h14);
    chk("s3_ptr", 0, 32'(ptr_o[0]), 32'h0004);

    // Offset then one data byte
    do_start(); do_addr(1'b0);
    chk("s4_ack_ofs", 0, 32'(ack_o[0]), 32'h1);
    do_offset(8'hAA, 8'hCC);
    chk("s4_ack_data", 0, 32'(ack_o[0]), 32'h0);
    chk("s4_ack_data", 1, 32'(ack_o[1]), 32'h1);
    do_data(8'h5A);
    chk("s4_wr", 1, 32'(wr_o[1]), 32'h1);
    chk("s4_wr_addr", 1, 32'(addr_o[1]), 32'hAACC);
    chk("s4_wr_data", 1, 32'(wd_o[1]), 32'h5A);
    chk("s4_wr", 0, 32'(wr_o[0]), 32'h0);
    do_stop(); idle(2);
    chk("s4_ptr", 0, 32'(ptr_o[0]), 32'hAACC);
    chk("s4_ptr", 1, 32'(ptr_o[1]), 32'hAACD);

    // Partial offset then STOP
    do_start(); do_addr(1'b0); do_rx(8'h12); do_stop(); idle(2);
    chk("s5_ptr", 0, 32'(ptr_o[0]), 32'hAACC);

    // Underrun: tx_req right after the read strobe
    do_start(); got2.delete();
    do_addr(1'b1);
    chk("s6_txd_req", 2, 32'(txd_o[2]), 32'hFF);
    do_txreq();
    chk("s6_underrun", 2, 32'(ur_o[2]), 32'h1);
    chk("s6_ptr", 2, 32'(ptr_o[2]), 32'hAACC);
    idle(6);
    do_txreq(); idle(6);
    chk("s6_byte", 2, 32'(got2[0]), 32'hDB);
    chk("s6_ptr_after", 2, 32'(ptr_o[2]), 32'hAACD);
    do_nack(); do_stop(); idle(2);

    // Asynchronous reset during a fetch
    do_start(); do_addr(1'b1);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_ptr", k, 32'(ptr_o[k]), 32'h0);
      chk("arst_rd", k, 32'(rd_o[k]), 32'h0);
      chk("arst_txd", k, 32'(txd_o[k]), 32'hFF);
      chk("arst_ack", k, 32'(ack_o[k]), 32'h1);
    end
    model_reset();
    for (int k = 0; k < 3; k++) rd_base[k] = rd_cnt[k];
    idle(3);
    rst_n = 1'b1;
    idle(8);
    chk("arst_no_rd", 0, 32'(rd_cnt[0] - rd_base[0]), 32'd0);
    chk("arst_no_rd", 2, 32'(rd_cnt[2] - rd_base[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
